// File: rtl/display_scheduler_pkg.sv
// Shared digit codes, FSM states and requester ids for the blackjack
// seven-segment display scheduler.
package bj_disp_pkg;

    localparam logic [3:0] D0 = 4'd0;
    localparam logic [3:0] D1 = 4'd1;
    localparam logic [3:0] D2 = 4'd2;
    localparam logic [3:0] D3 = 4'd3;
    localparam logic [3:0] D4 = 4'd4;
    localparam logic [3:0] D5 = 4'd5;
    localparam logic [3:0] D6 = 4'd6;
    localparam logic [3:0] D7 = 4'd7;
    localparam logic [3:0] D8 = 4'd8;
    localparam logic [3:0] D9 = 4'd9;
    localparam logic [3:0] Db = 4'd10;
    localparam logic [3:0] Dd = 4'd11;
    localparam logic [3:0] DA = 4'd12;
    localparam logic [3:0] DN = 4'd13;

    localparam logic [1:0] ID_RESULT = 2'd0;
    localparam logic [1:0] ID_DEALER = 2'd1;
    localparam logic [1:0] ID_PLAYER = 2'd2;
    localparam logic [1:0] ID_BET    = 2'd3;

    typedef enum logic [1:0] {
        S_ARB,
        S_CONV,
        S_COMMIT,
        S_HOLD
    } state_t;

    function automatic logic [3:0] tag_of(input logic [1:0] id);
        logic [3:0] t;
        unique case (id)
            ID_RESULT: t = DA;
            ID_DEALER: t = Dd;
            ID_PLAYER: t = DN;
            ID_BET:    t = Db;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Frame request bus between the game requesters and the display
// scheduler.
interface display_scheduler_if;
    logic [3:0]  req_valid;
    logic [3:0]  req_fmt;
    logic [23:0] req_hi;
    logic [23:0] req_lo;
    logic [3:0]  req_ack;

    modport master (
        output req_valid, req_fmt, req_hi, req_lo,
        input  req_ack
    );

    modport slave (
        input  req_valid, req_fmt, req_hi, req_lo,
        output req_ack
    );
endinterface

// File: rtl/display_scheduler_seg7_decode.sv
// Digit code to active-low segment pattern, bit 0 = a .. bit 6 = g.
module seg7_decode
    import bj_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1000000;
        unique case (code)
            D0:      seg = 7'b1000000;
            D1:      seg = 7'b1111001;
            D2:      seg = 7'b0100100;
            D3:      seg = 7'b0110000;
            D4:      seg = 7'b0011001;
            D5:      seg = 7'b0010010;
            D6:      seg = 7'b0000010;
            D7:      seg = 7'b1111000;
            D8:      seg = 7'b0000000;
            D9:      seg = 7'b0010000;
            Db:      seg = 7'b0000011;
            Dd:      seg = 7'b0100001;
            DA:      seg = 7'b0001000;
            DN:      seg = 7'b1111111;
            default: seg = 7'b1000000;
        endcase
    end
endmodule

// File: rtl/display_scheduler.sv
// Arbitrates display frames, converts them to decimal digits,
// commits all four digits at once and scans the display.
module display_scheduler
    import bj_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 5000,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    display_scheduler_if.slave bus,
    output logic [1:0]         shown_id,
    output logic               shown_valid,
    output logic               busy,
    output logic [3:0]         anode,
    output logic [6:0]         seg
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);

    state_t         state, state_nxt;
    logic [1:0]     gnt_id, cur_id;
    logic           gnt_fmt, cur_fmt;
    logic [5:0]     gnt_hi, gnt_lo;
    logic           any_req, grant, preempt, hold_done;
    logic [2:0]     conv_cnt, ten_hi, ten_lo;
    logic [5:0]     rem_hi, rem_lo;
    logic [HW-1:0]  hold_cnt;
    logic [3:0][3:0] dig;
    logic [SW-1:0]  scan_cnt;
    logic [1:0]     scan_idx;
    logic [6:0]     seg_dec;

    // Lowest index wins: scanning downward leaves the lowest set bit.
    always_comb begin
        gnt_id  = ID_RESULT;
        gnt_fmt = 1'b0;
        gnt_hi  = '0;
        gnt_lo  = '0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                gnt_id  = 2'(i);
                gnt_fmt = bus.req_fmt[i];
                gnt_hi  = bus.req_hi[6*i +: 6];
                gnt_lo  = bus.req_lo[6*i +: 6];
            end
        end
    end

    assign any_req   = |bus.req_valid;
    assign preempt   = bus.req_valid[0] && (shown_id != ID_RESULT);
    assign hold_done = hold_cnt == HW'(HOLD_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_ARB;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_ARB:    if (any_req) state_nxt = S_CONV;
            S_CONV:   if (conv_cnt == 3'd5) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_HOLD;
            S_HOLD:   if (preempt || hold_done) state_nxt = S_ARB;
            default:  state_nxt = S_ARB;
        endcase
    end

    always_comb begin
        grant = 1'b0;
        busy  = 1'b0;
        unique case (state)
            S_ARB:          grant = any_req;
            S_CONV, S_HOLD: busy  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.req_ack <= '0;
            cur_id      <= ID_RESULT;
            cur_fmt     <= 1'b0;
            rem_hi      <= '0;
            rem_lo      <= '0;
            ten_hi      <= '0;
            ten_lo      <= '0;
            conv_cnt    <= '0;
            hold_cnt    <= '0;
            dig         <= {4{DN}};
            shown_id    <= ID_RESULT;
            shown_valid <= 1'b0;
        end else begin
            bus.req_ack <= '0;
            if (grant) begin
                bus.req_ack <= 4'b0001 << gnt_id;
                cur_id      <= gnt_id;
                cur_fmt     <= gnt_fmt;
                rem_hi      <= gnt_hi;
                rem_lo      <= gnt_lo;
                ten_hi      <= '0;
                ten_lo      <= '0;
                conv_cnt    <= '0;
            end
            // Six subtract-10 steps cover the full 0..63 range.
            if (state == S_CONV) begin
                conv_cnt <= conv_cnt + 3'd1;
                if (rem_hi >= 6'd10) begin
                    rem_hi <= rem_hi - 6'd10;
                    ten_hi <= ten_hi + 3'd1;
                end
                if (rem_lo >= 6'd10) begin
                    rem_lo <= rem_lo - 6'd10;
                    ten_lo <= ten_lo + 3'd1;
                end
            end
            if (state == S_COMMIT) begin
                dig[3]      <= cur_fmt ? tag_of(cur_id) : {1'b0, ten_hi};
                dig[2]      <= cur_fmt ? DN : rem_hi[3:0];
                dig[1]      <= {1'b0, ten_lo};
                dig[0]      <= rem_lo[3:0];
                shown_id    <= cur_id;
                shown_valid <= 1'b1;
                hold_cnt    <= '0;
            end
            if (state == S_HOLD) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    seg7_decode u_dec (
        .code (dig[~scan_idx]),
        .seg  (seg_dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            anode    <= 4'b1111;
            seg      <= 7'b1111111;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            anode <= ~(4'b1000 >> scan_idx);
            seg   <= seg_dec;
        end
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Arbitrating sequencer for the shared 4-digit seven-segment display of the blackjack game. Requesters (result, dealer, player, bet) post a frame of two 6-bit binary values plus a format bit. The block grants one frame at a time, converts it to decimal digit codes with a fixed-latency sequential converter, and commits all four digits atomically. It holds the frame for a minimum time and drives the anode/segment scan. It sits between the game FSM (`top`) and the board pins.

## Interface
- `SCAN_DIV`, 5000: clock cycles each digit stays active in the scan.
- `HOLD_CYCLES`, 100_000_000: minimum cycles a committed frame is shown before re-arbitration; set ≥2 in simulation.
- `clk`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  4  per-requester frame request. Ids: 0=result, 1=dealer, 2=player, 3=bet.
- `req_fmt`  in  4  per requester. 0 = hi value on digits 3:2, lo value on digits 1:0. 1 = tag letter on digit 3, blank on digit 2, lo value on digits 1:0.
- `req_hi`  in  24  4×6-bit hi values; id i uses bits [6i+5:6i].
- `req_lo`  in  24  4×6-bit lo values, packed the same way as `req_hi`.
- `req_ack`  out  4  one-cycle grant pulse to the winning requester.
- `shown_id`  out  2  id of the committed frame.
- `shown_valid`  out  1  a frame has been committed since reset.
- `busy`  out  1  high in CONV and HOLD.
- `anode`  out  4  active-low digit enables.
- `seg`  out  7  active-low segments a–g.

## Operation
- FSM states: ARB → CONV → COMMIT → HOLD → ARB.
- **ARB**
  - If any `req_valid` bit is set, grant the lowest set index.
  - Capture that requester's hi, lo, fmt and id into internal registers.
  - Pulse `req_ack[id]` and go to CONV.
  - With no request, stay in ARB; the display keeps the last frame.
- **Handshake**
  - A requester holds `req_valid` and its data stable until it sees `req_ack`.
  - Data changes after the grant cycle are ignored.
  - Deasserting `req_valid` before grant withdraws the request.
- **CONV**
  - Runs exactly 6 cycles; hi and lo are converted in parallel.
  - Each cycle: if remainder ≥ 10, subtract 10 and increment the tens count.
  - Result: tens and ones, each 0..6 / 0..9 for inputs 0..63; leading zero is shown ("07").
- **COMMIT** (1 cycle): all four digit registers and `shown_id` update together, so there is no tearing. Set `shown_valid`.
- **Digit codes**: 0–9 digits, 10 = b, 11 = d, 12 = A, 13 = blank.
- **Tags** (used when fmt = 1): id 0 → A, id 1 → d, id 2 → blank, id 3 → b.
- **HOLD**
  - Count HOLD_CYCLES, then return to ARB.
  - Preemption: `req_valid[0]` while holding a frame with id ≠ 0 aborts HOLD and enters ARB the next cycle.
  - No preemption in CONV or COMMIT.
- **Scan**
  - Free-running counter 0..SCAN_DIV−1; on wrap, the digit index advances 0→1→2→3→0.
  - Index 0 → anode 0111, digit 3. Index 1 → 1011, digit 2. Index 2 → 1101, digit 1. Index 3 → 1110, digit 0.
  - `seg` is the decode of the selected digit code, registered together with `anode`.

## Timing
- **Reset values**
  - `req_ack` = 0, `shown_id` = 0, `shown_valid` = 0, `busy` = 0.
  - `anode` = 1111, `seg` = 1111111.
  - Digits all blank; FSM in ARB; scan counter and index 0.
- **Latency**
  - Grant decided in cycle G; `req_ack` high in G+1 (registered).
  - CONV occupies G+1..G+6; COMMIT in G+7.
  - New digits visible on `seg` at the next scan update of each digit.
  - HOLD from G+8; ARB is re-entered at G+8+HOLD_CYCLES.
- **Simultaneous events**
  - Several valid requests: only the lowest index is acked; the others stay pending.
  - `req_valid[0]` rising in the same cycle HOLD expires: normal ARB, and id 0 wins.
- **Reset mid-operation**: immediate return to reset values; a pending ack is not issued.

## Structure
- Shared package `bj_disp_pkg`:
  - digit-code constants D0–D9, Db, Dd, DA, DN;
  - FSM state enum;
  - requester id constants;
  - tag lookup by id.
- Sub-module `seg7_decode`: combinational 4-bit code → 7-bit active-low segment pattern, same code set as the board display (default pattern "0").

## Test plan
- Reset, then bet (id 3) requests fmt 1, lo = 5 → ack[3] at G+1; digits b,blank,0,5 at G+7; `shown_id` = 3.
- Player (id 2) fmt 0, hi = 21, lo = 10, with dealer (id 1) valid in the same cycle → ack[1] only. After dealer HOLD completes, ack[2]; digits 2,1,1,0.
- Dealer frame in HOLD (HOLD_CYCLES = 50), result id 0 requested at cycle 10 of HOLD → ARB next cycle; ack[0]; digits A,blank,lo.
- Values 0 and 63 → "00" and "63"; `req_hi` changed at G+2 → committed digits unchanged.
- SCAN_DIV = 4 → anode sequence 0111, 1011, 1101, 1110, each held 4 cycles; `seg` matches the digit codes.
- `reset_n` low during CONV → all outputs at reset values asynchronously; no ack issued.
